// File: rtl/mem_responder.sv
// Memory-side bus responder: word-addressed synchronous RAM with a memRd/memWr/MFC handshake
// and WAIT_STATES extra access cycles. Optional feature macro: MEM_RANGE_CHECK_EN (out-of-range detection).
module mem_responder #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] Abus,
  inout  wire  [DATA_W-1:0] Dbus,
  input  logic              memRd,
  input  logic              memWr,
  output logic              MFC,
  output logic              busErr
);

  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int WCNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [WCNT_W-1:0] WAIT_LOAD = WCNT_W'(WAIT_STATES);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  logic [1:0]            state_r;
  logic [1:0]            state_nxt_s;
  logic [WCNT_W-1:0]     wait_cnt_r;
  logic [WCNT_W-1:0]     wait_cnt_nxt_s;
  logic [ADDR_W-1:0]     addr_r;
  logic [DATA_W-1:0]     data_r;
  logic [DATA_W-1:0]     rd_data_r;
  logic                  is_wr_r;
  logic [DATA_W-1:0]     mem_r [DEPTH];

  logic                  start_s;
  logic                  req_held_s;
  logic                  wait_done_s;
  logic                  commit_s;
  logic                  out_of_range_s;
  logic                  ram_wr_en_s;
  logic                  dbus_oe_s;
  logic [DEPTH_LOG2-1:0] ram_idx_s;

  // Exactly one request line high starts an access; both high is a protocol violation and is ignored.
  assign start_s     = (state_r == IDLE) && (memRd ^ memWr);
  assign req_held_s  = is_wr_r ? memWr : memRd;
  assign wait_done_s = (wait_cnt_r == {WCNT_W{1'b0}});
  assign commit_s    = (state_r == ACCESS) && req_held_s && wait_done_s;
  assign ram_idx_s   = addr_r[DEPTH_LOG2-1:0];

`ifdef MEM_RANGE_CHECK_EN
  assign out_of_range_s = ((addr_r >> DEPTH_LOG2) != {ADDR_W{1'b0}});
  assign busErr         = (state_r == DONE) && out_of_range_s;
`else
  logic unused_addr_hi_s;
  // High address bits alias onto the implemented RAM.
  assign unused_addr_hi_s = |(addr_r >> DEPTH_LOG2);
  assign out_of_range_s   = 1'b0;
  assign busErr           = 1'b0;
`endif

  assign ram_wr_en_s = commit_s && is_wr_r && !out_of_range_s && !rst;
  assign MFC         = (state_r == DONE);
  assign dbus_oe_s   = (state_r == DONE) && !is_wr_r;
  assign Dbus        = dbus_oe_s ? rd_data_r : {DATA_W{1'bz}};

  // Next-state and wait-counter decode for the IDLE/ACCESS/DONE handshake.
  always_comb begin
    state_nxt_s    = state_r;
    wait_cnt_nxt_s = wait_cnt_r;
    case (state_r)
      IDLE: begin
        if (start_s) begin
          state_nxt_s    = ACCESS;
          wait_cnt_nxt_s = WAIT_LOAD;
        end else begin
          state_nxt_s    = IDLE;
        end
      end
      ACCESS: begin
        if (!req_held_s) begin
          state_nxt_s    = IDLE;
          wait_cnt_nxt_s = {WCNT_W{1'b0}};
        end else if (!wait_done_s) begin
          wait_cnt_nxt_s = wait_cnt_r - WCNT_W'(1);
        end else begin
          state_nxt_s    = DONE;
        end
      end
      DONE: begin
        if (req_held_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: begin
        state_nxt_s    = IDLE;
        wait_cnt_nxt_s = {WCNT_W{1'b0}};
      end
    endcase
  end

  // State, counter and request-latch registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      wait_cnt_r <= {WCNT_W{1'b0}};
      addr_r     <= {ADDR_W{1'b0}};
      data_r     <= {DATA_W{1'b0}};
      is_wr_r    <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
      if (start_s) begin
        addr_r  <= Abus;
        is_wr_r <= memWr;
        if (memWr) begin
          data_r <= Dbus;
        end
      end
    end
  end

  // Read data capture on the final ACCESS edge; out-of-range reads return zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_r <= {DATA_W{1'b0}};
    end else if (commit_s && !is_wr_r) begin
      rd_data_r <= out_of_range_s ? {DATA_W{1'b0}} : mem_r[ram_idx_s];
    end
  end

  // RAM array: no reset, contents survive rst.
  always_ff @(posedge clk) begin
    if (ram_wr_en_s) begin
      mem_r[ram_idx_s] <= data_r;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder: one instance with WAIT_STATES=2, one with WAIT_STATES=0.
module tb_mem_responder;

`ifdef MEM_RANGE_CHECK_EN
  localparam bit RANGE_CHK = 1'b1;
`else
  localparam bit RANGE_CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] abus, abus_z;
  logic        mem_rd, mem_wr, mem_rd_z, mem_wr_z;
  logic        drv, drv_z;
  logic [15:0] wdata, wdata_z;
  wire         mfc, bus_err, mfc_z, bus_err_z;
  tri1 [15:0]  dbus;
  tri1 [15:0]  dbus_z;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign dbus   = drv   ? wdata   : 16'hzzzz;
  assign dbus_z = drv_z ? wdata_z : 16'hzzzz;

  mem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(10), .WAIT_STATES(2)) u_dut (
    .clk(clk), .rst(rst), .Abus(abus), .Dbus(dbus), .memRd(mem_rd), .memWr(mem_wr),
    .MFC(mfc), .busErr(bus_err));

  mem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(10), .WAIT_STATES(0)) u_dut_ws0 (
    .clk(clk), .rst(rst), .Abus(abus_z), .Dbus(dbus_z), .memRd(mem_rd_z), .memWr(mem_wr_z),
    .MFC(mfc_z), .busErr(bus_err_z));

  // Full handshake on one instance; returns edges-to-MFC (-1 on timeout), bus data and busErr in DONE.
  task automatic xfer(input bit sel, input bit is_wr, input logic [15:0] addr, input logic [15:0] data,
                      output int lat, output logic [15:0] rdat, output logic err);
    lat = -1; rdat = 16'h0000; err = 1'b0;
    if (sel) begin
      abus_z = addr; mem_rd_z = !is_wr; mem_wr_z = is_wr; drv_z = is_wr; wdata_z = data;
    end else begin
      abus = addr; mem_rd = !is_wr; mem_wr = is_wr; drv = is_wr; wdata = data;
    end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if ((sel ? mfc_z : mfc) === 1'b1) begin
        lat  = i;
        rdat = sel ? dbus_z : dbus;
        err  = sel ? bus_err_z : bus_err;
        break;
      end
    end
    mem_rd = 1'b0; mem_wr = 1'b0; drv = 1'b0;
    mem_rd_z = 1'b0; mem_wr_z = 1'b0; drv_z = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    abus = 16'h0000; mem_rd = 1'b0; mem_wr = 1'b0; drv = 1'b0; wdata = 16'h0000;
    abus_z = 16'h0000; mem_rd_z = 1'b0; mem_wr_z = 1'b0; drv_z = 1'b0; wdata_z = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (mfc !== 1'b0) begin n_fail++; $display("FAIL reset_mfc: got %b expected 0", mfc); end
    n_cmp++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL reset_buserr: got %b expected 0", bus_err); end
    n_cmp++; if (dbus !== 16'hFFFF) begin n_fail++; $display("FAIL reset_dbus_z: got %h expected released (ffff)", dbus); end
    rst = 1'b0;
  endtask

  task automatic test_write;
    logic early;
    early = 1'b0;
    abus = 16'h0010; wdata = 16'h00A5; drv = 1'b1; mem_wr = 1'b1;
    for (int e = 0; e < 3; e++) begin
      @(posedge clk); #1;
      if (mfc !== 1'b0) early = 1'b1;
    end
    n_cmp++; if (early) begin n_fail++; $display("FAIL write_mfc_early: got 1 expected 0 before edge 3"); end
    @(posedge clk); #1;
    n_cmp++; if (mfc !== 1'b1) begin n_fail++; $display("FAIL write_mfc_edge3: got %b expected 1", mfc); end
    n_cmp++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL write_buserr: got %b expected 0", bus_err); end
    mem_wr = 1'b0; drv = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (mfc !== 1'b0) begin n_fail++; $display("FAIL write_mfc_drop: got %b expected 0", mfc); end
  endtask

  task automatic test_read_back;
    logic bad;
    bad = 1'b0;
    abus = 16'h0010; mem_rd = 1'b1;
    for (int e = 0; e < 3; e++) begin
      @(posedge clk); #1;
      if (mfc !== 1'b0 || dbus !== 16'hFFFF) bad = 1'b1;
    end
    n_cmp++; if (bad) begin n_fail++; $display("FAIL read_before_mfc: got mfc=%b dbus=%h expected mfc=0 dbus released", mfc, dbus); end
    abus = 16'h0333;
    @(posedge clk); #1;
    n_cmp++; if (mfc !== 1'b1) begin n_fail++; $display("FAIL read_mfc_edge3: got %b expected 1", mfc); end
    n_cmp++; if (dbus !== 16'h00A5) begin n_fail++; $display("FAIL read_data: got %h expected 00a5", dbus); end
    mem_rd = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (mfc !== 1'b0 || dbus !== 16'hFFFF) begin n_fail++; $display("FAIL read_release: got mfc=%b dbus=%h expected mfc=0 dbus=ffff", mfc, dbus); end
  endtask

  task automatic test_abort;
    int lat; logic [15:0] rd; logic err; logic seen;
    xfer(1'b0, 1'b1, 16'h0020, 16'h1111, lat, rd, err);
    abus = 16'h0020; wdata = 16'h1234; drv = 1'b1; mem_wr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    mem_wr = 1'b0; drv = 1'b0;
    seen = 1'b0;
    for (int e = 0; e < 6; e++) begin
      @(posedge clk); #1;
      if (mfc !== 1'b0) seen = 1'b1;
    end
    n_cmp++; if (seen) begin n_fail++; $display("FAIL abort_mfc: got 1 expected 0"); end
    xfer(1'b0, 1'b0, 16'h0020, 16'h0000, lat, rd, err);
    n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL abort_read_latency: got %0d expected 3", lat); end
    n_cmp++; if (rd !== 16'h1111) begin n_fail++; $display("FAIL abort_read_data: got %h expected 1111", rd); end
  endtask

  task automatic test_both_high;
    int lat; logic [15:0] rd; logic err; logic bad;
    xfer(1'b0, 1'b1, 16'h0030, 16'h7777, lat, rd, err);
    abus = 16'h0030; mem_rd = 1'b1; mem_wr = 1'b1; drv = 1'b0;
    bad = 1'b0;
    for (int e = 0; e < 5; e++) begin
      @(posedge clk); #1;
      if (mfc !== 1'b0 || dbus !== 16'hFFFF) bad = 1'b1;
    end
    n_cmp++; if (bad) begin n_fail++; $display("FAIL both_high: got mfc=%b dbus=%h expected mfc=0 dbus released", mfc, dbus); end
    mem_rd = 1'b0; mem_wr = 1'b0;
    @(posedge clk); #1;
    xfer(1'b0, 1'b0, 16'h0030, 16'h0000, lat, rd, err);
    n_cmp++; if (rd !== 16'h7777) begin n_fail++; $display("FAIL both_high_ram: got %h expected 7777", rd); end
  endtask

  task automatic test_reset_mid_op;
    int lat; logic [15:0] rd; logic err; logic bad;
    abus = 16'h0010; mem_rd = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (mfc !== 1'b0 || dbus !== 16'hFFFF) begin n_fail++; $display("FAIL rst_mid_read: got mfc=%b dbus=%h expected mfc=0 dbus=ffff", mfc, dbus); end
    bad = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (mfc !== 1'b0) bad = 1'b1;
    end
    n_cmp++; if (bad) begin n_fail++; $display("FAIL rst_hold_mfc: got 1 expected 0"); end
    rst = 1'b0; mem_rd = 1'b0;
    @(posedge clk); #1;
    xfer(1'b0, 1'b0, 16'h0010, 16'h0000, lat, rd, err);
    n_cmp++; if (rd !== 16'h00A5) begin n_fail++; $display("FAIL rst_read_after: got %h expected 00a5", rd); end
    // Reset in DONE keeps the committed write; reset in ACCESS discards the next one.
    abus = 16'h0040; wdata = 16'h4444; drv = 1'b1; mem_wr = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; mem_wr = 1'b0; drv = 1'b0;
    abus = 16'h0040; wdata = 16'h5555; drv = 1'b1; mem_wr = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; mem_wr = 1'b0; drv = 1'b0;
    @(posedge clk); #1;
    xfer(1'b0, 1'b0, 16'h0040, 16'h0000, lat, rd, err);
    n_cmp++; if (rd !== 16'h4444) begin n_fail++; $display("FAIL rst_commit_keep: got %h expected 4444", rd); end
  endtask

  task automatic test_out_of_range;
    int lat; logic [15:0] rd; logic err;
    logic [15:0] exp_alias;
    exp_alias = RANGE_CHK ? 16'h0123 : 16'hBEEF;
    xfer(1'b0, 1'b1, 16'h0000, 16'h0123, lat, rd, err);
    xfer(1'b0, 1'b1, 16'h0400, 16'hBEEF, lat, rd, err);
    n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL oor_wr_latency: got %0d expected 3", lat); end
    n_cmp++; if (err !== RANGE_CHK) begin n_fail++; $display("FAIL oor_wr_buserr: got %b expected %b", err, RANGE_CHK); end
    n_cmp++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL oor_buserr_after: got %b expected 0", bus_err); end
    xfer(1'b0, 1'b0, 16'h0000, 16'h0000, lat, rd, err);
    n_cmp++; if (rd !== exp_alias) begin n_fail++; $display("FAIL oor_ram0: got %h expected %h", rd, exp_alias); end
    xfer(1'b0, 1'b0, 16'h0400, 16'h0000, lat, rd, err);
    n_cmp++; if (rd !== (RANGE_CHK ? 16'h0000 : 16'hBEEF)) begin n_fail++; $display("FAIL oor_read: got %h expected %h", rd, RANGE_CHK ? 16'h0000 : 16'hBEEF); end
    n_cmp++; if (err !== RANGE_CHK) begin n_fail++; $display("FAIL oor_rd_buserr: got %b expected %b", err, RANGE_CHK); end
  endtask

  task automatic test_zero_wait;
    int lat; logic [15:0] rd; logic err;
    xfer(1'b1, 1'b1, 16'h0000, 16'h0321, lat, rd, err);
    xfer(1'b1, 1'b1, 16'h0400, 16'hBEEF, lat, rd, err);
    n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL ws0_wr_latency: got %0d expected 1", lat); end
    n_cmp++; if (err !== RANGE_CHK) begin n_fail++; $display("FAIL ws0_buserr: got %b expected %b", err, RANGE_CHK); end
    xfer(1'b1, 1'b0, 16'h0000, 16'h0000, lat, rd, err);
    n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL ws0_rd_latency: got %0d expected 1", lat); end
    n_cmp++; if (rd !== (RANGE_CHK ? 16'h0321 : 16'hBEEF)) begin n_fail++; $display("FAIL ws0_ram0: got %h expected %h", rd, RANGE_CHK ? 16'h0321 : 16'hBEEF); end
  endtask

  task automatic test_back_to_back;
    int lat; logic [15:0] rd; logic err;
    xfer(1'b0, 1'b1, 16'h0051, 16'hC3C3, lat, rd, err);
    xfer(1'b0, 1'b1, 16'h0052, 16'h3C3C, lat, rd, err);
    xfer(1'b0, 1'b0, 16'h0051, 16'h0000, lat, rd, err);
    n_cmp++; if (rd !== 16'hC3C3) begin n_fail++; $display("FAIL b2b_read_51: got %h expected c3c3", rd); end
    xfer(1'b0, 1'b0, 16'h0052, 16'h0000, lat, rd, err);
    n_cmp++; if (rd !== 16'h3C3C) begin n_fail++; $display("FAIL b2b_read_52: got %h expected 3c3c", rd); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_back();
    test_abort();
    test_both_high();
    test_reset_mid_op();
    test_out_of_range();
    test_zero_wait();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
